// File: rtl/alu_ctrl_seq.sv
// Registered ALU/MDU control decoder for the EX stage. Decodes ALUOp/funct3/funct7
// and sequences multi-cycle MUL/DIV ops with a latency counter.
module alu_ctrl_seq #(
  parameter int CTRL_W   = 5,
  parameter int EN_M_EXT = 1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 33
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        ALUOp_i,
  input  logic [2:0]        Funct3_i,
  input  logic [6:0]        Funct7_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              valid_o,
  output logic              illegal_o,
  output logic              mc_start_o,
  output logic              mc_busy_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLL   = 5'd2;
  localparam logic [4:0] OP_XOR   = 5'd3;
  localparam logic [4:0] OP_SRL   = 5'd4;
  localparam logic [4:0] OP_SRA   = 5'd5;
  localparam logic [4:0] OP_OR    = 5'd6;
  localparam logic [4:0] OP_AND   = 5'd7;
  localparam logic [4:0] OP_PASSB = 5'd8;
  localparam logic [4:0] OP_SLT   = 5'd9;
  localparam logic [4:0] OP_SLTU  = 5'd10;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic MUL_IS_MC = (MUL_LAT > 1);
  localparam logic DIV_IS_MC = (DIV_LAT > 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic {S_IDLE, S_MULTI} state_t;

  typedef struct packed {
    logic [4:0] op;
    logic       illegal;
  } dec_t;

  // Shared funct3 map for the base ALU ops (R-type with funct7=0, I-arith).
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    logic [4:0] op;
    op = OP_ADD;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic dec_t decode(input logic [2:0] aluop, input logic [2:0] f3,
                                  input logic [6:0] f7);
    dec_t d;
    d.op      = OP_ADD;
    d.illegal = 1'b0;
    case (aluop)
      3'b000: begin
        if (f7 == F7_ZERO) begin
          d.op = base_op(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          d.op = OP_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          d.op = OP_SRA;
        end else if (f7 == F7_MEXT && EN_M_EXT != 0) begin
          d.op = {2'b10, f3};
        end else begin
          d.illegal = 1'b1;
        end
      end
      3'b001, 3'b101: d.op = OP_ADD;
      3'b010:         d.op = OP_PASSB;
      3'b011: begin
        if (f3 == 3'b001) begin
          if (f7 == F7_ZERO) d.op = OP_SLL;
          else               d.illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          if (f7 == F7_ZERO)     d.op = OP_SRL;
          else if (f7 == F7_ALT) d.op = OP_SRA;
          else                   d.illegal = 1'b1;
        end else begin
          d.op = base_op(f3);
        end
      end
      3'b100: begin
        case (f3[2:1])
          2'b00:   d.op = OP_SUB;
          2'b10:   d.op = OP_SLT;
          2'b11:   d.op = OP_SLTU;
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) d.op = OP_ADD;
    return d;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic              illegal_q, illegal_d;
  logic              mc_start_q, mc_start_d;

  dec_t             dec;
  logic             accept;
  logic             is_mc;
  logic [CNT_W-1:0] lat_cnt;

  assign ready_o = (state_q == S_IDLE) && !stall_i && !flush_i;
  assign accept  = valid_i && ready_o;
  assign dec     = decode(ALUOp_i, Funct3_i, Funct7_i);
  // op[4] marks RV32M; op[2] splits DIV/REM from MUL within it.
  assign is_mc   = dec.op[4] && (dec.op[2] ? DIV_IS_MC : MUL_IS_MC);
  assign lat_cnt = dec.op[2] ? DIV_CNT : MUL_CNT;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_d     = ctrl_q;
    valid_d    = valid_q;
    illegal_d  = illegal_q;
    mc_start_d = 1'b0;
    if (flush_i) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      state_d   = S_IDLE;
      cnt_d     = '0;
    end else if (!stall_i) begin
      case (state_q)
        S_IDLE: begin
          valid_d = 1'b0;
          if (accept) begin
            ctrl_d    = CTRL_W'(dec.op);
            illegal_d = dec.illegal;
            if (is_mc) begin
              state_d    = S_MULTI;
              cnt_d      = lat_cnt;
              mc_start_d = 1'b1;
            end else begin
              valid_d = 1'b1;
            end
          end
        end
        default: begin
          // Completion edge: result due next cycle, ready again at the same time.
          if (cnt_q == CNT_W'(1)) begin
            valid_d = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            valid_d = 1'b0;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      mc_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
      mc_start_q <= mc_start_d;
    end
  end

  assign ALUCtrl_o  = ctrl_q;
  assign valid_o    = valid_q;
  assign illegal_o  = illegal_q;
  assign mc_start_o = mc_start_q;
  assign mc_busy_o  = (state_q == S_MULTI);

endmodule
